ex_mem_stage: RTL and testbench

- Pipeline register between the Execute stage (ALU result and NZVC flags) and the Memory stage.
- Holds the architected NZVC status register.
- Evaluates each instruction's condition code against that status register, and annuls the instruction's side effects when the condition fails.
- Supports stall (hold) and flush (bubble insertion) from the hazard unit.

---
 rtl/ex_mem_stage.sv | 112 +++++++++++
 tb/tb_ex_mem_stage.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register. It owns the architected NZVC flags and annuls
// instructions whose condition code fails against the flags that precede them.
module ex_mem_stage #(
  parameter int DATA_W = 32,
  parameter int RD_W   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              flush,
  input  logic              ex_valid,
  input  logic [DATA_W-1:0] ex_result,
  input  logic              ex_z,
  input  logic              ex_n,
  input  logic              ex_v,
  input  logic              ex_c,
  input  logic              ex_set_flags,
  input  logic [3:0]        ex_cond,
  input  logic [RD_W-1:0]   ex_rd,
  input  logic              ex_reg_write,
  input  logic              ex_mem_read,
  input  logic              ex_mem_write,
  input  logic [DATA_W-1:0] ex_store_data,
  output logic              mem_valid,
  output logic              mem_exec,
  output logic [DATA_W-1:0] mem_result,
  output logic [DATA_W-1:0] mem_store_data,
  output logic [RD_W-1:0]   mem_rd,
  output logic              mem_reg_write,
  output logic              mem_mem_read,
  output logic              mem_mem_write,
  output logic [3:0]        flags_nzvc
);

  typedef struct packed {
    logic              valid;
    logic              exec;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
    logic [RD_W-1:0]   rd;
    logic [DATA_W-1:0] result;
    logic [DATA_W-1:0] store_data;
  } mem_slot_t;

  mem_slot_t  slot_q, slot_d;
  logic [3:0] flags_q;
  logic       pass, fire;
  logic       f_n, f_z, f_v, f_c;

  assign {f_n, f_z, f_v, f_c} = flags_q;

  always_comb begin
    pass = 1'b0;
    case (ex_cond)
      4'b0000: pass = 1'b1;
      4'b0001: pass = f_z;
      4'b0010: pass = !f_z;
      4'b0011: pass = (f_n != f_v);
      4'b0100: pass = (f_n == f_v);
      4'b0101: pass = f_c;
      4'b0110: pass = !f_c;
      4'b0111: pass = !f_z && (f_n == f_v);
      4'b1000: pass = f_z || (f_n != f_v);
      default: pass = 1'b0;
    endcase
  end

  assign fire = ex_valid & pass;

  always_comb begin
    slot_d            = '0;
    slot_d.valid      = ex_valid;
    slot_d.exec       = fire;
    slot_d.reg_write  = ex_reg_write & fire;
    slot_d.mem_read   = ex_mem_read  & fire;
    slot_d.mem_write  = ex_mem_write & fire;
    slot_d.rd         = ex_rd;
    slot_d.result     = ex_result;
    slot_d.store_data = ex_store_data;
  end

  // Flush beats stall: the bubble goes in even while the pipe is frozen,
  // but data fields and flags are left untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q  <= '0;
      flags_q <= 4'b0000;
    end else if (flush) begin
      slot_q.valid     <= 1'b0;
      slot_q.exec      <= 1'b0;
      slot_q.reg_write <= 1'b0;
      slot_q.mem_read  <= 1'b0;
      slot_q.mem_write <= 1'b0;
    end else if (!stall) begin
      slot_q <= slot_d;
      if (fire && ex_set_flags)
        flags_q <= {ex_n, ex_z, ex_v, ex_c};
    end
  end

  assign mem_valid      = slot_q.valid;
  assign mem_exec       = slot_q.exec;
  assign mem_result     = slot_q.result;
  assign mem_store_data = slot_q.store_data;
  assign mem_rd         = slot_q.rd;
  assign mem_reg_write  = slot_q.reg_write;
  assign mem_mem_read   = slot_q.mem_read;
  assign mem_mem_write  = slot_q.mem_write;
  assign flags_nzvc     = flags_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed bench for ex_mem_stage: reset, capture, condition evaluation,
// stall/flush priority and flag sequencing with hand-computed expectations.
module tb_ex_mem_stage;
  localparam int DATA_W = 32;
  localparam int RD_W   = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              stall, flush;
  logic              ex_valid;
  logic [DATA_W-1:0] ex_result;
  logic              ex_z, ex_n, ex_v, ex_c;
  logic              ex_set_flags;
  logic [3:0]        ex_cond;
  logic [RD_W-1:0]   ex_rd;
  logic              ex_reg_write, ex_mem_read, ex_mem_write;
  logic [DATA_W-1:0] ex_store_data;
  logic              mem_valid, mem_exec;
  logic [DATA_W-1:0] mem_result, mem_store_data;
  logic [RD_W-1:0]   mem_rd;
  logic              mem_reg_write, mem_mem_read, mem_mem_write;
  logic [3:0]        flags_nzvc;

  int errors = 0;
  int checks = 0;

  ex_mem_stage #(.DATA_W(DATA_W), .RD_W(RD_W)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .ex_valid(ex_valid), .ex_result(ex_result),
    .ex_z(ex_z), .ex_n(ex_n), .ex_v(ex_v), .ex_c(ex_c),
    .ex_set_flags(ex_set_flags), .ex_cond(ex_cond), .ex_rd(ex_rd),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_store_data(ex_store_data),
    .mem_valid(mem_valid), .mem_exec(mem_exec), .mem_result(mem_result),
    .mem_store_data(mem_store_data), .mem_rd(mem_rd),
    .mem_reg_write(mem_reg_write), .mem_mem_read(mem_mem_read),
    .mem_mem_write(mem_mem_write), .flags_nzvc(flags_nzvc)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // nzvc packs the ALU flags as {N,Z,V,C}
  task automatic ex_op(input logic v, input logic [3:0] cond, input logic setf,
                       input logic [3:0] nzvc, input logic [DATA_W-1:0] res,
                       input logic [RD_W-1:0] rd, input logic rw, input logic mr,
                       input logic mw, input logic [DATA_W-1:0] sd);
    ex_valid = v; ex_cond = cond; ex_set_flags = setf;
    {ex_n, ex_z, ex_v, ex_c} = nzvc;
    ex_result = res; ex_rd = rd; ex_reg_write = rw;
    ex_mem_read = mr; ex_mem_write = mw; ex_store_data = sd;
  endtask

  task automatic test_reset();
    ex_op(1'b1, 4'b0000, 1'b1, 4'b1111, 32'hAAAA_5555, 4'hF, 1'b1, 1'b1, 1'b1, 32'hDEAD_BEEF);
    step();
    checks++;
    if ({mem_valid, mem_exec, mem_mem_write, flags_nzvc} !== 7'b111_1111) begin
      errors++; $display("FAIL reset_pre got=%b exp=1111111", {mem_valid, mem_exec, mem_mem_write, flags_nzvc});
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({mem_valid, mem_exec, mem_result, mem_store_data, mem_rd, mem_reg_write,
         mem_mem_read, mem_mem_write, flags_nzvc} !== '0) begin
      errors++; $display("FAIL reset_async got valid=%b res=%h sd=%h flags=%b exp all zero",
                         mem_valid, mem_result, mem_store_data, flags_nzvc);
    end
    step();
    checks++;
    if ({mem_valid, mem_exec, mem_result, mem_store_data, mem_rd, mem_reg_write,
         mem_mem_read, mem_mem_write, flags_nzvc} !== '0) begin
      errors++; $display("FAIL reset_hold got valid=%b res=%h flags=%b exp all zero",
                         mem_valid, mem_result, flags_nzvc);
    end
    ex_op(1'b0, 4'b0000, 1'b0, 4'b0000, '0, '0, 1'b0, 1'b0, 1'b0, '0);
    #2 rst_n = 1'b1;
  endtask

  task automatic test_capture();
    ex_op(1'b1, 4'b0000, 1'b1, 4'b0001, 32'h0000_0005, 4'd3, 1'b1, 1'b0, 1'b0, 32'h0);
    step();
    checks++;
    if (mem_result !== 32'h5 || mem_rd !== 4'd3) begin
      errors++; $display("FAIL cap_data got res=%h rd=%0d exp res=5 rd=3", mem_result, mem_rd);
    end
    checks++;
    if ({mem_valid, mem_exec, mem_reg_write, mem_mem_read, mem_mem_write} !== 5'b11100) begin
      errors++; $display("FAIL cap_ctrl got=%b exp=11100",
                         {mem_valid, mem_exec, mem_reg_write, mem_mem_read, mem_mem_write});
    end
    checks++;
    if (flags_nzvc !== 4'b0001) begin
      errors++; $display("FAIL cap_flags got=%b exp=0001", flags_nzvc);
    end
  endtask

  task automatic test_cond_chain();
    // SUB 7-7: zero, no borrow
    ex_op(1'b1, 4'b0000, 1'b1, 4'b0100, 32'h0, 4'd1, 1'b1, 1'b0, 1'b0, 32'h0);
    step();
    checks++;
    if (flags_nzvc !== 4'b0100) begin
      errors++; $display("FAIL chain_sub_flags got=%b exp=0100", flags_nzvc);
    end
    ex_op(1'b1, 4'b0001, 1'b0, 4'b0000, 32'h100, 4'd0, 1'b0, 1'b0, 1'b1, 32'h1234);
    step();
    checks++;
    if ({mem_exec, mem_mem_write} !== 2'b11 || mem_store_data !== 32'h1234) begin
      errors++; $display("FAIL chain_eq_store got exec=%b mw=%b sd=%h exp 1 1 1234",
                         mem_exec, mem_mem_write, mem_store_data);
    end
    ex_op(1'b1, 4'b0010, 1'b1, 4'b1001, 32'h104, 4'd0, 1'b0, 1'b0, 1'b1, 32'h5678);
    step();
    checks++;
    if ({mem_valid, mem_exec, mem_mem_write} !== 3'b100 || flags_nzvc !== 4'b0100) begin
      errors++; $display("FAIL chain_ne_annul got v/e/mw=%b flags=%b exp 100 0100",
                         {mem_valid, mem_exec, mem_mem_write}, flags_nzvc);
    end
  endtask

  task automatic test_stall_flush();
    ex_op(1'b1, 4'b0000, 1'b1, 4'b1000, 32'h11, 4'd5, 1'b1, 1'b0, 1'b0, 32'h22);
    step();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ex_op(i[0], 4'b0000, 1'b1, 4'b0111, 32'h900 + i, 4'd9, 1'b0, 1'b1, 1'b1, 32'hFF);
      step();
      checks++;
      if (mem_result !== 32'h11 || mem_rd !== 4'd5 || mem_store_data !== 32'h22 ||
          {mem_valid, mem_exec, mem_reg_write, mem_mem_read, mem_mem_write} !== 5'b11100 ||
          flags_nzvc !== 4'b1000) begin
        errors++; $display("FAIL stall_hold%0d got res=%h rd=%0d ctrl=%b flags=%b exp 11 5 11100 1000",
                           i, mem_result, mem_rd,
                           {mem_valid, mem_exec, mem_reg_write, mem_mem_read, mem_mem_write}, flags_nzvc);
      end
    end
    flush = 1'b1;
    ex_op(1'b1, 4'b0000, 1'b1, 4'b0011, 32'h33, 4'd6, 1'b1, 1'b1, 1'b1, 32'h44);
    step();
    checks++;
    if ({mem_valid, mem_exec, mem_reg_write, mem_mem_read, mem_mem_write} !== 5'b00000 ||
        flags_nzvc !== 4'b1000) begin
      errors++; $display("FAIL flush_over_stall got ctrl=%b flags=%b exp 00000 1000",
                         {mem_valid, mem_exec, mem_reg_write, mem_mem_read, mem_mem_write}, flags_nzvc);
    end
    stall = 1'b0; flush = 1'b0;
  endtask

  task automatic test_bubble_reserved();
    ex_op(1'b0, 4'b0000, 1'b1, 4'b0111, 32'h55, 4'd2, 1'b1, 1'b1, 1'b1, 32'h66);
    step();
    checks++;
    if ({mem_valid, mem_exec, mem_reg_write, mem_mem_read, mem_mem_write} !== 5'b00000 ||
        flags_nzvc !== 4'b1000) begin
      errors++; $display("FAIL bubble got ctrl=%b flags=%b exp 00000 1000",
                         {mem_valid, mem_exec, mem_reg_write, mem_mem_read, mem_mem_write}, flags_nzvc);
    end
    ex_op(1'b1, 4'b1011, 1'b1, 4'b1111, 32'h77, 4'd4, 1'b1, 1'b0, 1'b0, 32'h0);
    step();
    checks++;
    if ({mem_valid, mem_exec, mem_reg_write} !== 3'b100 || flags_nzvc !== 4'b1000) begin
      errors++; $display("FAIL reserved_cond got v/e/rw=%b flags=%b exp 100 1000",
                         {mem_valid, mem_exec, mem_reg_write}, flags_nzvc);
    end
  endtask

  task automatic test_signed();
    ex_op(1'b1, 4'b0000, 1'b1, 4'b1000, 32'h0, 4'd1, 1'b0, 1'b0, 1'b0, 32'h0);
    step();
    ex_op(1'b1, 4'b0011, 1'b0, 4'b0000, 32'h1, 4'd1, 1'b1, 1'b0, 1'b0, 32'h0);
    step();
    checks++;
    if ({mem_exec, mem_reg_write} !== 2'b11) begin
      errors++; $display("FAIL lt_n1v0 got e/rw=%b exp 11", {mem_exec, mem_reg_write});
    end
    ex_op(1'b1, 4'b0100, 1'b0, 4'b0000, 32'h2, 4'd1, 1'b1, 1'b0, 1'b0, 32'h0);
    step();
    checks++;
    if ({mem_exec, mem_reg_write} !== 2'b00) begin
      errors++; $display("FAIL ge_n1v0 got e/rw=%b exp 00", {mem_exec, mem_reg_write});
    end
    ex_op(1'b1, 4'b0000, 1'b1, 4'b1010, 32'h0, 4'd1, 1'b0, 1'b0, 1'b0, 32'h0);
    step();
    ex_op(1'b1, 4'b0100, 1'b0, 4'b0000, 32'h3, 4'd1, 1'b1, 1'b0, 1'b0, 32'h0);
    step();
    checks++;
    if (mem_exec !== 1'b1) begin
      errors++; $display("FAIL ge_n1v1 got=%b exp=1", mem_exec);
    end
    ex_op(1'b1, 4'b1000, 1'b0, 4'b0000, 32'h4, 4'd1, 1'b1, 1'b0, 1'b0, 32'h0);
    step();
    checks++;
    if (mem_exec !== 1'b0) begin
      errors++; $display("FAIL le_z0 got=%b exp=0", mem_exec);
    end
    ex_op(1'b1, 4'b0111, 1'b0, 4'b0000, 32'h5, 4'd1, 1'b1, 1'b0, 1'b0, 32'h0);
    step();
    checks++;
    if (mem_exec !== 1'b1) begin
      errors++; $display("FAIL gt_z0 got=%b exp=1", mem_exec);
    end
    // N=1,Z=1,V=1,C=1 then LE passes via Z, GT fails, LO passes, HS fails
    ex_op(1'b1, 4'b0000, 1'b1, 4'b1111, 32'h0, 4'd1, 1'b0, 1'b0, 1'b0, 32'h0);
    step();
    ex_op(1'b1, 4'b1000, 1'b0, 4'b0000, 32'h6, 4'd1, 1'b1, 1'b0, 1'b0, 32'h0);
    step();
    checks++;
    if (mem_exec !== 1'b1) begin
      errors++; $display("FAIL le_z1 got=%b exp=1", mem_exec);
    end
    ex_op(1'b1, 4'b0111, 1'b0, 4'b0000, 32'h7, 4'd1, 1'b1, 1'b0, 1'b0, 32'h0);
    step();
    checks++;
    if (mem_exec !== 1'b0) begin
      errors++; $display("FAIL gt_z1 got=%b exp=0", mem_exec);
    end
    ex_op(1'b1, 4'b0101, 1'b0, 4'b0000, 32'h8, 4'd1, 1'b0, 1'b1, 1'b0, 32'h0);
    step();
    checks++;
    if ({mem_exec, mem_mem_read} !== 2'b11) begin
      errors++; $display("FAIL lo_c1 got e/mr=%b exp 11", {mem_exec, mem_mem_read});
    end
    ex_op(1'b1, 4'b0110, 1'b0, 4'b0000, 32'h9, 4'd1, 1'b0, 1'b1, 1'b0, 32'h0);
    step();
    checks++;
    if ({mem_valid, mem_exec, mem_mem_read} !== 3'b100) begin
      errors++; $display("FAIL hs_c1 got v/e/mr=%b exp 100", {mem_valid, mem_exec, mem_mem_read});
    end
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
    ex_op(1'b0, 4'b0000, 1'b0, 4'b0000, '0, '0, 1'b0, 1'b0, 1'b0, '0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    step();
    test_reset();
    test_capture();
    test_cond_chain();
    test_stall_flush();
    test_bubble_reserved();
    test_signed();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
